// File: rtl/sha256_msg_sched_if.sv
// Handshake bundle between the padded-message generator, the schedule
// expander and the compression stage.
interface sha256_msg_sched_if;
    logic         pad_rdy;
    logic [511:0] pad_reg;
    logic         w_ready;
    logic         w_valid;
    logic [31:0]  w_data;
    logic [5:0]   w_index;
    logic         w_last;
    logic         sched_busy;
    logic         sched_done;

    modport master (
        output pad_rdy, pad_reg, w_ready,
        input  w_valid, w_data, w_index, w_last, sched_busy, sched_done
    );

    modport slave (
        input  pad_rdy, pad_reg, w_ready,
        output w_valid, w_data, w_index, w_last, sched_busy, sched_done
    );
endinterface

// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule expander: captures a 512-bit padded block and
// streams W0..W63 through a 16-word sliding window with valid/ready flow.
module sha256_msg_sched #(
    parameter int WORD_WIDTH = 32,
    parameter int NUM_ROUNDS = 64
) (
    input  logic               clock,
    input  logic               reset,
    sha256_msg_sched_if.slave  sif
);
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);
    localparam logic [5:0] PREV_IDX = 6'(NUM_ROUNDS - 2);

    state_t                state_r;
    logic [WORD_WIDTH-1:0] win_r [0:15];
    logic [5:0]            cnt_r;
    logic                  last_r;
    logic                  done_r;
    logic [WORD_WIDTH-1:0] new_word_s;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Next schedule word entering the top of the window.
    always_comb begin
        new_word_s = sig1(win_r[14]) + win_r[9] + sig0(win_r[1]) + win_r[0];
    end

    // Control FSM, window shift register and all output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 6'd0;
            last_r  <= 1'b0;
            done_r  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                win_r[i] <= 32'd0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    last_r <= 1'b0;
                    if (sif.pad_rdy) begin
                        for (int i = 0; i < 16; i++) begin
                            win_r[i] <= sif.pad_reg[511-32*i -: 32];
                        end
                        cnt_r   <= 6'd0;
                        state_r <= ST_STREAM;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_STREAM: begin
                    // pad_rdy is deliberately ignored here; the block in flight owns the window.
                    if (sif.w_ready) begin
                        for (int i = 0; i < 15; i++) begin
                            win_r[i] <= win_r[i+1];
                        end
                        win_r[15] <= new_word_s;
                        cnt_r     <= cnt_r + 6'd1;
                        if (cnt_r == LAST_IDX) begin
                            state_r <= ST_IDLE;
                            done_r  <= 1'b1;
                            last_r  <= 1'b0;
                        end else begin
                            state_r <= ST_STREAM;
                            done_r  <= 1'b0;
                            last_r  <= (cnt_r == PREV_IDX);
                        end
                    end else begin
                        state_r <= ST_STREAM;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    last_r  <= 1'b0;
                end
            endcase
        end
    end

    assign sif.w_valid    = (state_r == ST_STREAM);
    assign sif.sched_busy = (state_r == ST_STREAM);
    assign sif.w_data     = win_r[0];
    assign sif.w_index    = cnt_r;
    assign sif.w_last     = last_r;
    assign sif.sched_done = done_r;
endmodule

// File: tb/tb_sha256_msg_sched.sv
// Scoreboard bench for sha256_msg_sched: stimulus pushes expected words,
// a negedge monitor pops and compares every accepted word.
module tb_sha256_msg_sched;
    logic clock;
    logic reset;
    sha256_msg_sched_if sif ();

    sha256_msg_sched dut (.clock(clock), .reset(reset), .sif(sif));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int fails  = 0;

    logic [37:0] exp_q [$];
    logic [31:0] gw  [64];
    logic [31:0] got [64];
    logic        exp_done = 1'b0;
    logic        held     = 1'b0;
    logic [38:0] hold_v;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic gen_sched(input logic [511:0] blk);
        for (int t = 0; t < 16; t++) gw[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            gw[t] = s1(gw[t-2]) + gw[t-7] + s0(gw[t-15]) + gw[t-16];
    endtask

    task automatic push_block(input logic [511:0] blk);
        gen_sched(blk);
        for (int t = 0; t < 64; t++) exp_q.push_back({6'(t), gw[t]});
    endtask

    // Scoreboard monitor: sample away from the rising edge.
    always @(negedge clock) begin
        if (!reset) begin
            held     = 1'b0;
            exp_done = 1'b0;
        end else begin
            chk("sched_done", {63'd0, sif.sched_done}, {63'd0, exp_done});
            exp_done = 1'b0;
            if (sif.w_valid) begin
                if (held)
                    chk("stall_hold", {25'd0, sif.w_last, sif.w_index, sif.w_data}, {25'd0, hold_v});
                if (sif.w_ready) begin
                    held = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", {26'd0, sif.w_index, sif.w_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        logic [37:0] e;
                        e = exp_q.pop_front();
                        chk("word", {25'd0, sif.w_last, sif.w_index, sif.w_data},
                            {25'd0, (e[37:32] == 6'd63), e});
                        got[sif.w_index] = sif.w_data;
                        if (e[37:32] == 6'd63) exp_done = 1'b1;
                    end
                end else begin
                    held   = 1'b1;
                    hold_v = {sif.w_last, sif.w_index, sif.w_data};
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic chk_outputs_zero(input string name);
        chk(name, {sif.w_valid, sif.w_last, sif.sched_busy, sif.sched_done, sif.w_index, sif.w_data},
            64'd0);
    endtask

    // Pulses pad_rdy for one edge and checks the capture latency.
    task automatic capture(input logic [511:0] blk);
        @(posedge clock); #1;
        sif.pad_reg = blk;
        sif.pad_rdy = 1'b1;
        @(posedge clock); #1;
        sif.pad_rdy = 1'b0;
        chk("capture_valid_idx", {57'd0, sif.w_valid, sif.w_index}, {57'd0, 1'b1, 6'd0});
    endtask

    task automatic drain(input bit rnd, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || sif.w_valid) && n < budget) begin
            sif.w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clock); #1;
            n++;
        end
        sif.w_ready = 1'b1;
        chk("drain_timeout", 64'(n < budget), 64'd1);
        @(posedge clock); #1;
        @(posedge clock); #1;
    endtask

    task automatic wait_index(input logic [5:0] idx);
        int n = 0;
        while (sif.w_index != idx && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        chk("wait_index_timeout", 64'(n < 200), 64'd1);
    endtask

    logic [511:0] abc_blk;
    logic [511:0] m55_blk;
    logic [511:0] other_blk;
    logic [439:0] m55;

    initial begin
        abc_blk   = {32'h6162_6380, 448'd0, 32'h0000_0018};
        m55       = "abcdefghijklmnopqrstuvwxyzabcdefghijklmnopqrstuvwxyzabc";
        m55_blk   = {m55, 8'h80, 64'd440};
        other_blk = {16{32'hDEAD_BEEF}};
        reset       = 1'b0;
        sif.pad_rdy = 1'b0;
        sif.pad_reg = 512'd0;
        sif.w_ready = 1'b1;

        // Reset held with noisy inputs.
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            sif.pad_reg = {16{$urandom()}};
            sif.pad_rdy = 1'($urandom_range(0, 1));
            chk_outputs_zero("reset_outputs");
        end
        sif.pad_rdy = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            chk_outputs_zero("post_reset_idle");
        end

        // "abc" block, full throughput.
        push_block(abc_blk);
        capture(abc_blk);
        repeat (63) @(posedge clock);
        #1;
        chk("w63_last", {57'd0, sif.w_last, sif.w_index}, {57'd0, 1'b1, 6'd63});
        @(posedge clock); #1;
        chk("completion", {61'd0, sif.w_valid, sif.sched_busy, sif.sched_done}, 64'd1);
        drain(1'b0, 50);
        chk("abc_w0",  64'(got[0]),  64'h6162_6380);
        chk("abc_w15", 64'(got[15]), 64'h0000_0018);
        chk("abc_w16", 64'(got[16]), 64'h6162_6380);
        chk("abc_w17", 64'(got[17]), 64'h000F_0000);
        chk("abc_w18", 64'(got[18]), 64'h7DA8_6405);

        // Backpressure.
        push_block(abc_blk);
        capture(abc_blk);
        drain(1'b1, 1000);

        // pad_rdy during STREAM is ignored.
        push_block(abc_blk);
        capture(abc_blk);
        wait_index(6'd20);
        sif.pad_reg = other_blk;
        sif.pad_rdy = 1'b1;
        @(posedge clock); #1;
        sif.pad_rdy = 1'b0;
        drain(1'b0, 200);

        // Back-to-back blocks with re-pulse in the sched_done cycle.
        push_block(m55_blk);
        push_block(m55_blk);
        capture(m55_blk);
        begin
            int n = 0;
            while (!sif.sched_done && n < 200) begin
                @(posedge clock); #1;
                n++;
            end
            chk("b2b_done_timeout", 64'(n < 200), 64'd1);
        end
        sif.pad_reg = m55_blk;
        sif.pad_rdy = 1'b1;
        @(posedge clock); #1;
        sif.pad_rdy = 1'b0;
        chk("b2b_restart", {57'd0, sif.w_valid, sif.w_index}, {57'd0, 1'b1, 6'd0});
        drain(1'b0, 200);

        // Reset mid-stream.
        push_block(abc_blk);
        capture(abc_blk);
        wait_index(6'd30);
        #2;
        reset = 1'b0;
        #1;
        chk_outputs_zero("mid_reset_async");
        exp_q.delete();
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        chk_outputs_zero("after_mid_reset");
        @(posedge clock); #1;
        push_block(abc_blk);
        capture(abc_blk);
        drain(1'b0, 200);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/sha256_msg_sched.md
# sha256_msg_sched

Message-schedule expander for the SHA256 accelerator. It sits directly downstream of the padded-message generator. On the generator's one-cycle ready pulse it captures the 512-bit padded block. It then streams the 64 schedule words W0..W63 to the compression stage, one 32-bit word per accepted handshake, with backpressure. Capturing a private copy frees the generator to start the next block while streaming is in progress.

## Interface
Parameters
- WORD_WIDTH, 32: schedule word width; fixed by SHA256, not intended to be overridden.
- NUM_ROUNDS, 64: words emitted per block.

Ports
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- pad_rdy  input  1  one-cycle pulse from the padded-message generator; pad_reg is valid in that cycle.
- pad_reg  input  512  padded block; bits [511:480] hold W0, bits [31:0] hold W15 (big-endian, first message character in the MSB).
- w_ready  input  1  compression stage can accept w_data this cycle.
- w_valid  output  1  w_data/w_index hold a valid word (registered).
- w_data  output  32  current schedule word W[w_index] (registered).
- w_index  output  6  round number 0..63 of w_data (registered).
- w_last  output  1  high with w_valid when w_index==63 (registered).
- sched_busy  output  1  block captured, not all 64 words accepted yet (registered).
- sched_done  output  1  one-cycle pulse after W63 is accepted (registered).

## Operation
- State storage: 16-entry x 32-bit sliding window win[0..15], where win[i]=W[t+i] and t=w_index. Also a 6-bit round counter and a state register.
- States:
  - IDLE: waits for a capture.
    - IDLE -> STREAM on pad_rdy=1.
    - Capture: win[i] <= pad_reg[511-32i -: 32], counter <= 0.
  - STREAM: emits words.
    - Advance occurs on w_valid & w_ready.
    - On advance: win[i] <= win[i+1] for i=0..14; win[15] <= σ1(win[14]) + win[9] + σ0(win[1]) + win[0], modulo 2^32; counter increments.
    - STREAM -> IDLE on the advance with counter==63.
- Functions:
  - σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
  - All additions are 32-bit, with carries out discarded.
- Output mapping:
  - w_data = win[0].
  - w_index = counter.
  - w_valid = (state==STREAM).
  - w_last = w_valid & (counter==63).
  - sched_busy = w_valid.
- Expansion beyond W63 is not needed. The values computed into win[15] during the final 15 advances are don't-care.
- pad_rdy while in STREAM is ignored: no recapture and no effect on the stream in progress. The upstream controller must not pulse pad_rdy while sched_busy=1.

## Timing
- Reset (asynchronous, active-low): state=IDLE, counter=0, window cleared to 0. Every output is 0: w_valid, w_data, w_index, w_last, sched_busy, sched_done.
- Reset asserted mid-stream: the stream is aborted immediately and all outputs return to 0 without waiting for a clock edge. No sched_done is produced.
- Capture latency: pad_rdy sampled high at edge N gives w_valid=1, w_index=0, w_data=W0 after edge N.
- Word handshake: a word is consumed at an edge where w_valid=1 and w_ready=1. The next word appears after that same edge.
- Throughput: with w_ready held high, 64 words take 64 consecutive cycles.
- Stall: while w_ready=0, w_data, w_index and w_last hold stable, and the window does not shift.
- Completion: at the edge accepting W63, w_valid, w_last and sched_busy fall to 0 and sched_done=1 for exactly one cycle.
- Back-to-back blocks: pad_rdy is accepted in the sched_done cycle, because the state is already IDLE. The minimum block-to-block period is 65 cycles.
- No combinational path from any input to any output.

## Test plan
- Reset values: hold reset=0 with random pad_reg and pad_rdy toggling -> all outputs 0 and no capture. Release reset -> outputs stay 0 until pad_rdy.
- "abc" block: pad_reg = 0x61626380, followed by 448 zero bits, followed by 0x00000018; pulse pad_rdy; w_ready=1.
  - W0 = 0x61626380, W1..W14 = 0, W15 = 0x00000018, W16 = 0x61626380, W17 = 0x000F0000, W18 = 0x7DA86405.
  - W0..W63 all match the C golden model.
  - w_last is high only at index 63; sched_done pulses one cycle later.
- Backpressure: same block with w_ready pseudo-random (about 50%) -> identical 64-word sequence. Outputs stay stable during every stall cycle, and no word is duplicated or dropped.
- pad_rdy during STREAM: pulse pad_rdy with a different block at index 20 -> the stream continues with the original block's W21..W63, and the second block is not captured.
- Back-to-back: the 55-character message block from message55.dat with pad_rdy re-pulsed in the sched_done cycle -> the second stream starts the next cycle with w_index=0. Both streams match the golden model.
- Reset mid-operation: assert reset at index 30 while w_valid=1 -> w_valid=0 immediately with no sched_done. After release, a new pad_rdy yields a correct stream from W0.
